// File: rtl/calendar_set_core.sv
// Real-time calendar/clock with a mode/plus/minus field-set FSM.
// Keeps binary time registers; BCD outputs are decoded from them.
module calendar_set_core #(
  parameter int unsigned SEC_DIV   = 40000000,
  parameter int unsigned YEAR_BASE = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode,
  input  logic        plus,
  input  logic        minus,
  input  logic        h12,
  output logic [15:0] year_bcd,
  output logic [7:0]  mon_bcd,
  output logic [7:0]  day_bcd,
  output logic [7:0]  hour_bcd,
  output logic [7:0]  min_bcd,
  output logic [7:0]  sec_bcd,
  output logic        pm,
  output logic [4:0]  field_sel,
  output logic        sec_tick
);

  localparam int unsigned   PW        = $clog2(SEC_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SEC_DIV - 1);

  typedef enum logic [2:0] {
    S_RUN,
    S_SET_YEAR,
    S_SET_MON,
    S_SET_DAY,
    S_SET_HOUR,
    S_SET_MIN
  } state_t;

  state_t        r_state;
  logic [4:0]    r_field_sel;
  logic [PW-1:0] r_presc;
  logic [6:0]    r_year_off;
  logic [3:0]    r_mon;
  logic [4:0]    r_day;
  logic [4:0]    r_hour;
  logic [5:0]    r_min;
  logic [5:0]    r_sec;

  logic          w_tick;
  logic          w_up;
  logic          w_dn;
  logic          w_adj;
  logic [4:0]    w_dim;
  logic [4:0]    w_dim_ymod;
  logic [4:0]    w_dim_mmod;
  logic [6:0]    w_year_step;
  logic [3:0]    w_mon_step;
  logic [4:0]    w_day_step;
  logic [4:0]    w_hour_step;
  logic [5:0]    w_min_step;
  state_t        w_state_nxt;
  logic [4:0]    w_sel_nxt;
  logic [4:0]    w_hour_disp;
  logic [15:0]   w_year;

  // Only the low two bits of the full year matter for the leap test.
  function automatic logic f_leap(input logic [6:0] off);
    logic [1:0] s;
    s = 2'(YEAR_BASE) + off[1:0];
    return (s == 2'b00);
  endfunction

  function automatic logic [4:0] f_dim(input logic [3:0] mon, input logic leap);
    logic [4:0] d;
    case (mon)
      4'd2:                    d = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] f_bcd2(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  always_comb begin
    w_tick = (r_state == S_RUN) && (r_presc == PRESC_MAX);
    w_up   = plus  & ~minus & ~mode;
    w_dn   = minus & ~plus  & ~mode;
    w_adj  = w_up | w_dn;
    w_dim  = f_dim(r_mon, f_leap(r_year_off));

    if (w_up) begin
      w_year_step = (r_year_off >= 7'd99) ? 7'd0  : r_year_off + 7'd1;
      w_mon_step  = (r_mon >= 4'd12)      ? 4'd1  : r_mon + 4'd1;
      w_day_step  = (r_day >= w_dim)      ? 5'd1  : r_day + 5'd1;
      w_hour_step = (r_hour >= 5'd23)     ? 5'd0  : r_hour + 5'd1;
      w_min_step  = (r_min >= 6'd59)      ? 6'd0  : r_min + 6'd1;
    end else begin
      w_year_step = (r_year_off == 7'd0)  ? 7'd99 : r_year_off - 7'd1;
      w_mon_step  = (r_mon <= 4'd1)       ? 4'd12 : r_mon - 4'd1;
      w_day_step  = (r_day <= 5'd1)       ? w_dim : r_day - 5'd1;
      w_hour_step = (r_hour == 5'd0)      ? 5'd23 : r_hour - 5'd1;
      w_min_step  = (r_min == 6'd0)       ? 6'd59 : r_min - 6'd1;
    end

    // Month length after a year/month edit, used to clamp the day.
    w_dim_ymod = f_dim(r_mon, f_leap(w_year_step));
    w_dim_mmod = f_dim(w_mon_step, f_leap(r_year_off));

    case (r_state)
      S_RUN: begin
        w_state_nxt = S_SET_YEAR;
        w_sel_nxt   = 5'b00001;
      end
      S_SET_YEAR: begin
        w_state_nxt = S_SET_MON;
        w_sel_nxt   = 5'b00010;
      end
      S_SET_MON: begin
        w_state_nxt = S_SET_DAY;
        w_sel_nxt   = 5'b00100;
      end
      S_SET_DAY: begin
        w_state_nxt = S_SET_HOUR;
        w_sel_nxt   = 5'b01000;
      end
      S_SET_HOUR: begin
        w_state_nxt = S_SET_MIN;
        w_sel_nxt   = 5'b10000;
      end
      default: begin
        w_state_nxt = S_RUN;
        w_sel_nxt   = 5'b00000;
      end
    endcase

    if (!h12)
      w_hour_disp = r_hour;
    else if (r_hour == 5'd0)
      w_hour_disp = 5'd12;
    else if (r_hour > 5'd12)
      w_hour_disp = r_hour - 5'd12;
    else
      w_hour_disp = r_hour;

    w_year = 16'(YEAR_BASE) + {9'd0, r_year_off};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_field_sel <= '0;
      r_presc     <= '0;
      r_year_off  <= '0;
      r_mon       <= 4'd1;
      r_day       <= 5'd1;
      r_hour      <= '0;
      r_min       <= '0;
      r_sec       <= '0;
    end else begin
      if (mode) begin
        r_state     <= w_state_nxt;
        r_field_sel <= w_sel_nxt;
      end

      case (r_state)
        S_RUN: begin
          // Full carry chain resolves on the tick edge; a same-cycle mode
          // pulse still lets the tick through.
          if (w_tick) begin
            r_presc <= '0;
            if (r_sec == 6'd59) begin
              r_sec <= '0;
              if (r_min == 6'd59) begin
                r_min <= '0;
                if (r_hour == 5'd23) begin
                  r_hour <= '0;
                  if (r_day >= w_dim) begin
                    r_day <= 5'd1;
                    if (r_mon >= 4'd12) begin
                      r_mon      <= 4'd1;
                      r_year_off <= (r_year_off >= 7'd99) ? 7'd0 : r_year_off + 7'd1;
                    end else begin
                      r_mon <= r_mon + 4'd1;
                    end
                  end else begin
                    r_day <= r_day + 5'd1;
                  end
                end else begin
                  r_hour <= r_hour + 5'd1;
                end
              end else begin
                r_min <= r_min + 6'd1;
              end
            end else begin
              r_sec <= r_sec + 6'd1;
            end
          end else begin
            r_presc <= r_presc + PW'(1);
          end
        end
        S_SET_YEAR: begin
          if (w_adj) begin
            r_year_off <= w_year_step;
            if (r_day > w_dim_ymod) r_day <= w_dim_ymod;
          end
        end
        S_SET_MON: begin
          if (w_adj) begin
            r_mon <= w_mon_step;
            if (r_day > w_dim_mmod) r_day <= w_dim_mmod;
          end
        end
        S_SET_DAY: begin
          if (w_adj) r_day <= w_day_step;
        end
        S_SET_HOUR: begin
          if (w_adj) r_hour <= w_hour_step;
        end
        S_SET_MIN: begin
          if (mode) begin
            r_sec   <= '0;
            r_presc <= '0;
          end else if (w_adj) begin
            r_min <= w_min_step;
          end
        end
        default: begin
          r_presc <= '0;
        end
      endcase
    end
  end

  // h12 is a static display-format level, so it steers the hour decode directly.
  assign year_bcd  = {4'(w_year / 16'd1000 % 16'd10), 4'(w_year / 16'd100 % 16'd10),
                      4'(w_year / 16'd10 % 16'd10),   4'(w_year % 16'd10)};
  assign mon_bcd   = f_bcd2({3'd0, r_mon});
  assign day_bcd   = f_bcd2({2'd0, r_day});
  assign hour_bcd  = f_bcd2({2'd0, w_hour_disp});
  assign min_bcd   = f_bcd2({1'b0, r_min});
  assign sec_bcd   = f_bcd2({1'b0, r_sec});
  assign pm        = (r_hour >= 5'd12);
  assign field_sel = r_field_sel;
  assign sec_tick  = w_tick;

endmodule

// File: tb/tb_calendar_set_core.sv
// Randomised and directed bench for calendar_set_core against a calendar model.
module tb_calendar_set_core;

  localparam int unsigned SEC_DIV = 4;
  localparam int          YB      = 2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mode = 1'b0;
  logic        plus = 1'b0;
  logic        minus = 1'b0;
  logic        h12 = 1'b0;
  logic [15:0] year_bcd;
  logic [7:0]  mon_bcd;
  logic [7:0]  day_bcd;
  logic [7:0]  hour_bcd;
  logic [7:0]  min_bcd;
  logic [7:0]  sec_bcd;
  logic        pm;
  logic [4:0]  field_sel;
  logic        sec_tick;

  calendar_set_core #(.SEC_DIV(SEC_DIV), .YEAR_BASE(YB)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .plus(plus), .minus(minus), .h12(h12),
    .year_bcd(year_bcd), .mon_bcd(mon_bcd), .day_bcd(day_bcd), .hour_bcd(hour_bcd),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .pm(pm), .field_sel(field_sel),
    .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic chk_on = 1'b0;

  // Model: m_st 0=running, 1..5 = editing year, month, day, hour, minute.
  int m_st = 0, m_presc = 0;
  int m_year = YB, m_mon = 1, m_day = 1, m_hour = 0, m_min = 0, m_sec = 0;

  function automatic int dim_of(int y, int m);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic int wrap(int v, int lo, int hi);
    int n;
    n = hi - lo + 1;
    return (((v - lo) % n) + n) % n + lo;
  endfunction

  task automatic m_reset();
    m_st = 0; m_presc = 0;
    m_year = YB; m_mon = 1; m_day = 1; m_hour = 0; m_min = 0; m_sec = 0;
  endtask

  task automatic m_second();
    m_sec++;
    if (m_sec == 60) begin
      m_sec = 0; m_min++;
      if (m_min == 60) begin
        m_min = 0; m_hour++;
        if (m_hour == 24) begin
          m_hour = 0; m_day++;
          if (m_day > dim_of(m_year, m_mon)) begin
            m_day = 1; m_mon++;
            if (m_mon > 12) begin
              m_mon = 1; m_year++;
              if (m_year > YB + 99) m_year = YB;
            end
          end
        end
      end
    end
  endtask

  task automatic m_step(input logic md, input logic p, input logic n);
    int d;
    if (m_st == 0) begin
      if (m_presc == int'(SEC_DIV) - 1) begin
        m_presc = 0;
        m_second();
      end else begin
        m_presc++;
      end
      if (md) m_st = 1;
    end else if (md) begin
      if (m_st == 5) begin
        m_st = 0; m_sec = 0; m_presc = 0;
      end else begin
        m_st++;
      end
    end else if (p != n) begin
      d = p ? 1 : -1;
      case (m_st)
        1: begin
          m_year = wrap(m_year + d, YB, YB + 99);
          if (m_day > dim_of(m_year, m_mon)) m_day = dim_of(m_year, m_mon);
        end
        2: begin
          m_mon = wrap(m_mon + d, 1, 12);
          if (m_day > dim_of(m_year, m_mon)) m_day = dim_of(m_year, m_mon);
        end
        3: m_day  = wrap(m_day + d, 1, dim_of(m_year, m_mon));
        4: m_hour = wrap(m_hour + d, 0, 23);
        default: m_min = wrap(m_min + d, 0, 59);
      endcase
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_step(mode, plus, minus);
  end

  function automatic logic [7:0] bcd2(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [62:0] exp_vec();
    int hd;
    logic [4:0] fs;
    hd = m_hour;
    if (h12) hd = (m_hour == 0) ? 12 : (m_hour > 12 ? m_hour - 12 : m_hour);
    fs = (m_st == 0) ? 5'd0 : 5'(1 << (m_st - 1));
    return {4'(m_year / 1000 % 10), 4'(m_year / 100 % 10), 4'(m_year / 10 % 10), 4'(m_year % 10),
            bcd2(m_mon), bcd2(m_day), bcd2(hd), bcd2(m_min), bcd2(m_sec),
            (m_hour >= 12), fs, (m_st == 0 && m_presc == int'(SEC_DIV) - 1)};
  endfunction

  task automatic checker_loop();
    logic [62:0] act, ex;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        act = {year_bcd, mon_bcd, day_bcd, hour_bcd, min_bcd, sec_bcd, pm, field_sel, sec_tick};
        ex  = exp_vec();
        n_cmp++;
        if (act !== ex) begin
          n_fail++;
          $display("FAIL cycle_model t=%0t got %h expected %h (model state %0d)", $time, act, ex, m_st);
        end
      end
    end
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] ex);
    n_cmp++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, ex);
    end
  endtask

  task automatic pulse(input logic md, input logic p, input logic n);
    @(posedge clk); #1;
    mode = md; plus = p; minus = n;
    @(posedge clk); #1;
    mode = 1'b0; plus = 1'b0; minus = 1'b0;
  endtask

  task automatic goto_st(input int target);
    for (int i = 0; i < 6 && m_st != target; i++) pulse(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, last;
    fork checker_loop(); join_none
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_year", year_bcd, 16'h2000);
    check("rst_mon_day", {mon_bcd, day_bcd}, 16'h0101);
    check("rst_hour_min", {hour_bcd, min_bcd}, 16'h0000);
    check("rst_sec", {8'h00, sec_bcd}, 16'h0000);
    check("rst_flags", {9'd0, pm, field_sel, sec_tick}, 16'h0000);
    h12 = 1'b1;
    @(negedge clk);
    check("rst_hour_h12", {8'h00, hour_bcd}, 16'h0012);
    h12 = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("first_second", {8'h00, sec_bcd}, 16'h0001);

    // Load 2023-12-31 23:59 and run two minutes across the new year.
    goto_st(1);
    for (int i = 0; i < 23; i++) pulse(1'b0, 1'b1, 1'b0);
    check("set_year", year_bcd, 16'h2023);
    goto_st(2); pulse(1'b0, 1'b0, 1'b1);
    goto_st(3); pulse(1'b0, 1'b0, 1'b1);
    goto_st(4); pulse(1'b0, 1'b0, 1'b1);
    goto_st(5); pulse(1'b0, 1'b0, 1'b1);
    check("loaded_md", {mon_bcd, day_bcd}, 16'h1231);
    check("loaded_hm", {hour_bcd, min_bcd}, 16'h2359);
    goto_st(0);
    check("exit_sec_sel", {3'd0, field_sel, sec_bcd}, 16'h0000);
    for (int pass = 0; pass < 2; pass++) begin
      cnt = 0; last = -1;
      for (int k = 0; k < 240; k++) begin
        @(negedge clk);
        if (sec_tick) begin
          if (last >= 0) check("tick_gap", 16'(k - last), 16'd4);
          last = k; cnt++;
        end
      end
      check("tick_count", 16'(cnt), 16'd60);
      @(posedge clk); #1;
      check("ny_year", year_bcd, 16'h2024);
      check("ny_md", {mon_bcd, day_bcd}, 16'h0101);
      check("ny_hm", {hour_bcd, min_bcd}, (pass == 0) ? 16'h0000 : 16'h0001);
      check("ny_sec", {8'h00, sec_bcd}, 16'h0000);
    end

    // Day clamping on month change, common and leap years.
    goto_st(1); pulse(1'b0, 1'b0, 1'b1);
    check("year_2023", year_bcd, 16'h2023);
    goto_st(3);
    for (int i = 0; i < 40 && m_day != 31; i++) pulse(1'b0, 1'b1, 1'b0);
    goto_st(2); pulse(1'b0, 1'b1, 1'b0);
    check("clamp_2023", {mon_bcd, day_bcd}, 16'h0228);
    goto_st(1); pulse(1'b0, 1'b1, 1'b0);
    goto_st(2); pulse(1'b0, 1'b0, 1'b1);
    goto_st(3);
    for (int i = 0; i < 40 && m_day != 31; i++) pulse(1'b0, 1'b1, 1'b0);
    check("day_31", {8'h00, day_bcd}, 16'h0031);
    goto_st(2); pulse(1'b0, 1'b1, 1'b0);
    check("clamp_2024", {mon_bcd, day_bcd}, 16'h0229);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    check("mon_wrap_dn", {8'h00, mon_bcd}, 16'h0012);

    // Field wrap limits with no carry.
    goto_st(1);
    for (int i = 0; i < 101 && m_year != YB + 99; i++) pulse(1'b0, 1'b0, 1'b1);
    check("year_2099", year_bcd, 16'h2099);
    pulse(1'b0, 1'b1, 1'b0);
    check("year_wrap_up", year_bcd, 16'h2000);
    goto_st(4);
    for (int i = 0; i < 25 && m_hour != 5; i++) pulse(1'b0, 1'b1, 1'b0);
    goto_st(5);
    for (int i = 0; i < 61 && m_min != 0; i++) pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    check("min_wrap_no_carry", {hour_bcd, min_bcd}, 16'h0559);

    // 12-hour display.
    goto_st(4);
    h12 = 1'b1;
    for (int i = 0; i < 25 && m_hour != 0; i++) pulse(1'b0, 1'b0, 1'b1);
    check("h12_0", {7'd0, pm, hour_bcd}, 16'h0012);
    for (int i = 0; i < 25 && m_hour != 12; i++) pulse(1'b0, 1'b1, 1'b0);
    check("h12_12", {7'd0, pm, hour_bcd}, 16'h0112);
    pulse(1'b0, 1'b1, 1'b0);
    check("h12_13", {7'd0, pm, hour_bcd}, 16'h0101);
    h12 = 1'b0;
    @(negedge clk);
    check("h24_13", {8'h00, hour_bcd}, 16'h0013);
    h12 = 1'b1;
    @(negedge clk);
    check("h12_back", {8'h00, hour_bcd}, 16'h0001);
    h12 = 1'b0;

    // Simultaneous inputs and reset during setting.
    goto_st(3);
    for (int i = 0; i < 32 && m_day != 10; i++) pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    check("mode_wins", {3'd0, field_sel, day_bcd}, 16'h0810);
    pulse(1'b0, 1'b1, 1'b1);
    check("plus_minus_nop", {3'd0, field_sel, hour_bcd}, 16'h0813);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort_year", year_bcd, 16'h2000);
    check("abort_md", {mon_bcd, day_bcd}, 16'h0101);
    check("abort_hms", {hour_bcd, min_bcd}, 16'h0000);
    check("abort_sel", {3'd0, field_sel, sec_bcd}, 16'h0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // mode coinciding with a tick: tick applied and SET_YEAR entered.
    for (int i = 0; i < 8 && !(m_st == 0 && m_presc == int'(SEC_DIV) - 1); i++) @(negedge clk);
    mode = 1'b1;
    @(posedge clk); #1 mode = 1'b0;
    check("tick_and_mode", {3'd0, field_sel, sec_bcd}, 16'h0101);

    goto_st(0);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      mode  = ($urandom_range(0, 99) < 6);
      plus  = ($urandom_range(0, 3) == 0);
      minus = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 199) == 0) h12 = ~h12;
      rst_n = ($urandom_range(0, 999) != 0);
    end
    @(posedge clk); #1;
    mode = 1'b0; plus = 1'b0; minus = 1'b0; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
